// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcodes, field positions and format classes.
package mips_defs;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_R    = 2'd1,
    FMT_I    = 2'd2,
    FMT_J    = 2'd3
  } fmt_e;

  function automatic fmt_e opc_fmt(input logic [5:0] opc);
    case (opc)
      OPC_RTYPE:      return FMT_R;
      OPC_J, OPC_JAL: return FMT_J;
      default:        return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side handshake, flush and decoded-field bundle for the decode stage.
interface instr_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm16;
  logic [25:0]     out_jaddr;
  logic [PC_W-1:0] out_pc_plus4;
  logic [4:0]      out_dest;
  logic            out_is_r;
  logic            out_is_i;
  logic            out_is_j;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm16, out_jaddr, out_pc_plus4, out_dest,
           out_is_r, out_is_i, out_is_j
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm16, out_jaddr, out_pc_plus4, out_dest,
           out_is_r, out_is_i, out_is_j
  );
endinterface

// File: rtl/instr_decode_stage_skid_buffer.sv
// Two-entry valid/ready register: main entry drives the output, skid entry
// absorbs the word accepted during the cycle the output stalls.
module skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             main_free;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
  assign in_fire     = in_valid_i & ~skid_v_q;
  assign main_free   = ~main_v_q | out_ready_i;

  // The skid entry is only ever full while main is full, so refilling main
  // from skid never competes with an incoming word (in_ready is low then).
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_d   = in_data_i;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  // Payload is qualified by the valid flags, so it carries no reset.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Fetch-to-decode stage: buffers {instr, pc} in a skid buffer and splits the
// MIPS fields of the head entry; all fields read zero while no word is held.
module instr_decode_stage
  import mips_defs::*;
#(
  parameter int PC_W    = 32,
  parameter int JAL_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_decode_stage_if.slave  bus
);
  logic               head_v;
  logic [31+PC_W:0]   head_data;
  logic [31:0]        ir;
  logic [PC_W-1:0]    pc;
  fmt_e               fmt;

  skid_buffer #(.WIDTH(32 + PC_W)) u_skid (
    .clk         (clk),
    .rst         (reset),
    .flush_i     (bus.flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({bus.in_instr, bus.in_pc}),
    .out_valid_o (head_v),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head_data)
  );

  assign ir  = head_data[PC_W +: 32];
  assign pc  = head_data[PC_W-1:0];
  assign fmt = head_v ? opc_fmt(ir[OPC_LSB +: 6]) : FMT_NONE;

  always_comb begin
    bus.out_valid    = head_v;
    bus.out_opcode   = '0;
    bus.out_rs       = '0;
    bus.out_rt       = '0;
    bus.out_rd       = '0;
    bus.out_shamt    = '0;
    bus.out_funct    = '0;
    bus.out_imm16    = '0;
    bus.out_jaddr    = '0;
    bus.out_pc_plus4 = '0;
    bus.out_dest     = '0;
    bus.out_is_r     = (fmt == FMT_R);
    bus.out_is_i     = (fmt == FMT_I);
    bus.out_is_j     = (fmt == FMT_J);
    if (head_v) begin
      bus.out_opcode   = ir[OPC_LSB +: 6];
      bus.out_rs       = ir[RS_LSB +: 5];
      bus.out_rt       = ir[RT_LSB +: 5];
      bus.out_rd       = ir[RD_LSB +: 5];
      bus.out_shamt    = ir[SHAMT_LSB +: 5];
      bus.out_funct    = ir[FUNCT_LSB +: 6];
      bus.out_imm16    = ir[15:0];
      bus.out_jaddr    = ir[25:0];
      bus.out_pc_plus4 = pc + PC_W'(4);
      case (fmt)
        FMT_R:   bus.out_dest = ir[RD_LSB +: 5];
        FMT_I:   bus.out_dest = ir[RT_LSB +: 5];
        FMT_J:   bus.out_dest = (ir[OPC_LSB +: 6] == OPC_JAL) ? 5'(JAL_REG) : 5'd0;
        default: bus.out_dest = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode classes, back-pressure, flush,
// pc wrap, throughput and asynchronous reset.
module tb_instr_decode_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   seen;

  always #5 clk = ~clk;

  instr_decode_stage_if #(.PC_W(32)) bus ();

  instr_decode_stage #(.PC_W(32), .JAL_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_dest",      64'(bus.out_dest),  64'd0);
    check("rst_imm16",     64'(bus.out_imm16), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);
    check("rel_in_ready",  64'(bus.in_ready),  64'd1);

    // I-type
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h2128FFFF, 32'h00400000);
    step();
    check("i_valid",  64'(bus.out_valid),    64'd1);
    check("i_opcode", 64'(bus.out_opcode),   64'h08);
    check("i_rs",     64'(bus.out_rs),       64'd9);
    check("i_rt",     64'(bus.out_rt),       64'd8);
    check("i_imm16",  64'(bus.out_imm16),    64'hFFFF);
    check("i_dest",   64'(bus.out_dest),     64'd8);
    check("i_is_i",   64'(bus.out_is_i),     64'd1);
    check("i_is_r",   64'(bus.out_is_r),     64'd0);
    check("i_is_j",   64'(bus.out_is_j),     64'd0);
    check("i_pc4",    64'(bus.out_pc_plus4), 64'h00400004);

    // R-type, jal, j back to back
    drive(1'b1, 32'h00221820, 32'h00000100);
    step();
    check("r_rs",    64'(bus.out_rs),    64'd1);
    check("r_rt",    64'(bus.out_rt),    64'd2);
    check("r_rd",    64'(bus.out_rd),    64'd3);
    check("r_shamt", 64'(bus.out_shamt), 64'd0);
    check("r_funct", 64'(bus.out_funct), 64'h20);
    check("r_dest",  64'(bus.out_dest),  64'd3);
    check("r_is_r",  64'(bus.out_is_r),  64'd1);
    check("r_is_i",  64'(bus.out_is_i),  64'd0);
    drive(1'b1, 32'h0C000010, 32'h00000104);
    step();
    check("jal_is_j",  64'(bus.out_is_j),  64'd1);
    check("jal_jaddr", 64'(bus.out_jaddr), 64'h10);
    check("jal_dest",  64'(bus.out_dest),  64'd31);
    drive(1'b1, 32'h08000010, 32'h00000108);
    step();
    check("j_is_j",   64'(bus.out_is_j),   64'd1);
    check("j_dest",   64'(bus.out_dest),   64'd0);
    check("j_opcode", 64'(bus.out_opcode), 64'h02);

    // pc wrap
    drive(1'b1, 32'h2128FFFF, 32'hFFFFFFFC);
    step();
    check("wrap_valid", 64'(bus.out_valid),    64'd1);
    check("wrap_pc4",   64'(bus.out_pc_plus4), 64'h0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_imm16", 64'(bus.out_imm16), 64'd0);
    check("idle_is_i",  64'(bus.out_is_i),  64'd0);

    // back-pressure: A, B, C with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h20010001, 32'h00001000);
    step();
    check("bp_a_rt",    64'(bus.out_rt),    64'd1);
    check("bp_a_ready", 64'(bus.in_ready),  64'd1);
    drive(1'b1, 32'h20020002, 32'h00001004);
    step();
    check("bp_b_hold_rt", 64'(bus.out_rt),   64'd1);
    check("bp_b_ready",   64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h20030003, 32'h00001008);
    step();
    check("bp_c_hold_rt", 64'(bus.out_rt),   64'd1);
    check("bp_c_ready",   64'(bus.in_ready), 64'd0);
    step();
    check("bp_stable_pc4", 64'(bus.out_pc_plus4), 64'h00001004);
    check("bp_stable_imm", 64'(bus.out_imm16),    64'h0001);
    bus.out_ready = 1'b1;
    step();
    check("bp_out_b_rt",  64'(bus.out_rt),    64'd2);
    check("bp_out_b_vld", 64'(bus.out_valid), 64'd1);
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_out_c_rt",  64'(bus.out_rt),       64'd3);
    check("bp_out_c_pc4", 64'(bus.out_pc_plus4), 64'h0000100C);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // flush with main and skid full plus an incoming word
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h20040004, 32'h00002000);
    step();
    drive(1'b1, 32'h20050005, 32'h00002004);
    step();
    check("fl_full_ready", 64'(bus.in_ready),  64'd0);
    check("fl_full_valid", 64'(bus.out_valid), 64'd1);
    drive(1'b1, 32'h20060006, 32'h00002008);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_ready", 64'(bus.in_ready),  64'd1);
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fl_no_emit", 64'(bus.out_valid), 64'd0);
    end

    // flush drops an incoming word even while in_ready is high
    drive(1'b1, 32'h20070007, 32'h00003000);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_drop_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("fl_drop_later", 64'(bus.out_valid), 64'd0);

    // throughput: 100 words, out_ready high
    seen = 0;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) drive(1'b1, {6'h08, 5'd0, 5'd0, 16'(c)}, 32'(c * 4));
      else         drive(1'b0, 32'h0, 32'h0);
      step();
      if (bus.out_valid) begin
        check("thr_order", 64'(bus.out_imm16), 64'(seen));
        seen++;
      end
    end
    check("thr_count", 64'(seen), 64'd100);

    // asynchronous reset mid-operation
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h20080008, 32'h00004000);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_ready", 64'(bus.in_ready),  64'd1);
    check("ar_rt",    64'(bus.out_rt),    64'd0);
    #1 reset = 1'b0;
    step();
    check("ar_after", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
